// File: rtl/fcpu_pkg.sv
// fcpu shared package: core sizing constants, commit classification and
// the reorder-buffer entry layout.
//   No ports; imported by the ROB interface and the ROB top.
package fcpu_pkg;

   localparam int unsigned N_ROB_W    = 4;
   localparam int unsigned ROB_DEPTH  = 1 << N_ROB_W;
   localparam int unsigned N_CDB      = 2;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;

   // How a retiring instruction is applied to architectural state.
   typedef enum logic [2:0] {
      commit_alu    = 3'd0,
      commit_load   = 3'd1,
      commit_store  = 3'd2,
      commit_branch = 3'd3,
      commit_nop    = 3'd4
   } commit_type_t;

   typedef logic [N_ROB_W-1:0] rob_tag_t;

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic                  mispredict;
      commit_type_t          ctype;
      logic [REG_ADDR_W-1:0] dst_reg;
      logic [DATA_W-1:0]     data;
   } rob_entry_t;

endpackage

// File: rtl/fcpu_rob_if.sv
// Reorder-buffer interface: dispatch allocation, CDB write-back, in-order
// commit and flush/occupancy status.
//   master : dispatch/cdb/commit_ready producer (core side, bench)
//   slave  : the reorder buffer itself
interface fcpu_rob_if;
   import fcpu_pkg::*;

   logic                      dispatch_valid;
   logic                      dispatch_ready;
   commit_type_t              dispatch_type;
   logic [REG_ADDR_W-1:0]     dispatch_dst_reg;
   rob_tag_t                  dispatch_tag;

   logic [N_CDB-1:0]          cdb_valid;
   logic [N_CDB*N_ROB_W-1:0]  cdb_tag;
   logic [N_CDB*DATA_W-1:0]   cdb_data;
   logic [N_CDB-1:0]          cdb_mispredict;

   logic                      commit_valid;
   logic                      commit_ready;
   commit_type_t              commit_type;
   logic [REG_ADDR_W-1:0]     commit_dst_reg;
   logic [DATA_W-1:0]         commit_data;
   rob_tag_t                  commit_tag;

   logic                      flush;
   logic [N_ROB_W:0]          count;

   modport master (
      output dispatch_valid, dispatch_type, dispatch_dst_reg,
      output cdb_valid, cdb_tag, cdb_data, cdb_mispredict,
      output commit_ready,
      input  dispatch_ready, dispatch_tag,
      input  commit_valid, commit_type, commit_dst_reg, commit_data, commit_tag,
      input  flush, count
   );

   modport slave (
      input  dispatch_valid, dispatch_type, dispatch_dst_reg,
      input  cdb_valid, cdb_tag, cdb_data, cdb_mispredict,
      input  commit_ready,
      output dispatch_ready, dispatch_tag,
      output commit_valid, commit_type, commit_dst_reg, commit_data, commit_tag,
      output flush, count
   );

endinterface

// File: rtl/fcpu_rob.sv
// fcpu reorder buffer: allocates in-order tags at dispatch, captures
// out-of-order CDB results, retires one entry per cycle in program order
// and pulses flush after a mispredicted branch retires.
//   clk, rst : clock, asynchronous active-high reset
//   rob      : fcpu_rob_if.slave (dispatch, cdb, commit, flush, count)
module fcpu_rob (
   input  logic       clk,
   input  logic       rst,
   fcpu_rob_if.slave  rob
);
   import fcpu_pkg::*;

   localparam int unsigned PTR_W = N_ROB_W + 1;

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   rob_entry_t       entries [ROB_DEPTH];
   logic             flush_q;

   rob_tag_t         head_idx;
   rob_tag_t         tail_idx;
   rob_entry_t       head_e;
   logic             full;
   logic             commit_fire;
   logic             flush_fire;
   logic             dispatch_fire;

   rob_tag_t         cdb_tag_p  [N_CDB];
   logic [DATA_W-1:0] cdb_data_p [N_CDB];

   assign head_idx = head[N_ROB_W-1:0];
   assign tail_idx = tail[N_ROB_W-1:0];
   assign head_e   = entries[head_idx];

   // Wrap bits differ with equal indices: every slot is occupied.
   assign full = (head[N_ROB_W] != tail[N_ROB_W]) && (head_idx == tail_idx);

   assign commit_fire   = rob.commit_valid && rob.commit_ready;
   assign flush_fire    = commit_fire && (head_e.ctype == commit_branch) && head_e.mispredict;
   // No pass-through: a same-cycle commit never frees a slot for dispatch.
   assign dispatch_fire = rob.dispatch_valid && rob.dispatch_ready;

   assign rob.dispatch_ready = !rst && !full && !flush_fire;
   assign rob.dispatch_tag   = tail_idx;
   assign rob.commit_valid   = head_e.valid && head_e.done;
   assign rob.commit_type    = head_e.ctype;
   assign rob.commit_dst_reg = head_e.dst_reg;
   assign rob.commit_data    = head_e.data;
   assign rob.commit_tag     = head_idx;
   assign rob.flush          = flush_q;
   assign rob.count          = tail - head;

   // Unpack the flat CDB buses into per-port fields.
   always_comb begin
      for (int p = 0; p < int'(N_CDB); p++) begin
         cdb_tag_p[p]  = rob.cdb_tag[p*N_ROB_W +: N_ROB_W];
         cdb_data_p[p] = rob.cdb_data[p*DATA_W +: DATA_W];
      end
   end

   // Head/tail pointers and the one-cycle flush pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         flush_q <= 1'b0;
      end else begin
         flush_q <= flush_fire;
         if (commit_fire)
            head <= head + PTR_W'(1);
         if (flush_fire)
            tail <= head + PTR_W'(1);
         else if (dispatch_fire)
            tail <= tail + PTR_W'(1);
      end
   end

   // Entry array: allocate at tail, retire at head, CDB capture anywhere.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(ROB_DEPTH); i++)
            entries[i] <= '0;
      end else if (flush_fire) begin
         for (int i = 0; i < int'(ROB_DEPTH); i++) begin
            entries[i].valid      <= 1'b0;
            entries[i].done       <= 1'b0;
            entries[i].mispredict <= 1'b0;
         end
      end else begin
         for (int i = 0; i < int'(ROB_DEPTH); i++) begin
            if (commit_fire && (head_idx == N_ROB_W'(i)))
               entries[i].valid <= 1'b0;
            if (dispatch_fire && (tail_idx == N_ROB_W'(i))) begin
               entries[i].valid      <= 1'b1;
               entries[i].done       <= 1'b0;
               entries[i].mispredict <= 1'b0;
               entries[i].ctype      <= rob.dispatch_type;
               entries[i].dst_reg    <= rob.dispatch_dst_reg;
               entries[i].data       <= '0;
            end
            // Highest port first so the lowest-index port's write lands last.
            for (int p = int'(N_CDB) - 1; p >= 0; p--) begin
               if (rob.cdb_valid[p] && (cdb_tag_p[p] == N_ROB_W'(i)) && entries[i].valid &&
                   !(dispatch_fire && (tail_idx == N_ROB_W'(i)))) begin
                  entries[i].done       <= 1'b1;
                  entries[i].data       <= cdb_data_p[p];
                  entries[i].mispredict <= (entries[i].ctype == commit_branch) && rob.cdb_mispredict[p];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fcpu_rob.sv
// Directed testbench for fcpu_rob: fill/full, out-of-order completion,
// dual-port CDB, mispredict flush, full-buffer commit/dispatch, async reset.
module tb_fcpu_rob;
   import fcpu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fcpu_rob_if rob_if ();
   fcpu_rob dut (.clk(clk), .rst(rst), .rob(rob_if));

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cdb_set(input int p, input logic [N_ROB_W-1:0] tag,
                          input logic [DATA_W-1:0] d, input logic m);
      rob_if.cdb_valid[p]                     = 1'b1;
      rob_if.cdb_tag[p*N_ROB_W +: N_ROB_W]    = tag;
      rob_if.cdb_data[p*DATA_W +: DATA_W]     = d;
      rob_if.cdb_mispredict[p]                = m;
   endtask

   task automatic cdb_clear();
      rob_if.cdb_valid      = '0;
      rob_if.cdb_tag        = '0;
      rob_if.cdb_data       = '0;
      rob_if.cdb_mispredict = '0;
   endtask

   initial begin
      rst                     = 1'b1;
      rob_if.dispatch_valid   = 1'b0;
      rob_if.dispatch_type    = commit_alu;
      rob_if.dispatch_dst_reg = '0;
      rob_if.commit_ready     = 1'b0;
      cdb_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_commit_valid", 64'(rob_if.commit_valid), 64'd0);
      chk("rst_count", 64'(rob_if.count), 64'd0);
      chk("rst_dispatch_ready", 64'(rob_if.dispatch_ready), 64'd0);
      chk("rst_dispatch_tag", 64'(rob_if.dispatch_tag), 64'd0);
      chk("rst_flush", 64'(rob_if.flush), 64'd0);
      rst = 1'b0;
      tick();

      // Fill all 16 slots, dst 1..16.
      for (int i = 0; i < 16; i++) begin
         rob_if.dispatch_valid   = 1'b1;
         rob_if.dispatch_dst_reg = 5'(i + 1);
         #1;
         chk("fill_ready", 64'(rob_if.dispatch_ready), 64'd1);
         chk("fill_tag", 64'(rob_if.dispatch_tag), 64'(i));
         tick();
      end
      chk("full_ready", 64'(rob_if.dispatch_ready), 64'd0);
      rob_if.dispatch_valid = 1'b0;
      chk("full_count", 64'(rob_if.count), 64'd16);

      // Out-of-order completion 3,1,0,2; in-order retirement.
      rob_if.commit_ready = 1'b1;
      cdb_set(0, 4'd3, 32'hA3, 1'b0);
      tick(); cdb_clear();
      chk("ooo_pending_a", 64'(rob_if.commit_valid), 64'd0);
      cdb_set(0, 4'd1, 32'hA1, 1'b0);
      tick(); cdb_clear();
      chk("ooo_pending_b", 64'(rob_if.commit_valid), 64'd0);
      cdb_set(0, 4'd0, 32'hA0, 1'b0);
      #1;
      chk("ooo_pending_c", 64'(rob_if.commit_valid), 64'd0);
      tick(); cdb_clear();
      cdb_set(0, 4'd2, 32'hA2, 1'b0);
      #1;
      chk("c0_valid", 64'(rob_if.commit_valid), 64'd1);
      chk("c0_tag", 64'(rob_if.commit_tag), 64'd0);
      chk("c0_data", 64'(rob_if.commit_data), 64'hA0);
      chk("c0_dst", 64'(rob_if.commit_dst_reg), 64'd1);
      tick(); cdb_clear();
      chk("c1_valid", 64'(rob_if.commit_valid), 64'd1);
      chk("c1_tag", 64'(rob_if.commit_tag), 64'd1);
      chk("c1_data", 64'(rob_if.commit_data), 64'hA1);
      tick();
      chk("c2_tag", 64'(rob_if.commit_tag), 64'd2);
      chk("c2_data", 64'(rob_if.commit_data), 64'hA2);
      chk("c2_valid", 64'(rob_if.commit_valid), 64'd1);
      tick();
      chk("c3_tag", 64'(rob_if.commit_tag), 64'd3);
      chk("c3_data", 64'(rob_if.commit_data), 64'hA3);
      chk("c3_valid", 64'(rob_if.commit_valid), 64'd1);
      tick();
      chk("c4_not_done", 64'(rob_if.commit_valid), 64'd0);
      chk("after_ooo_count", 64'(rob_if.count), 64'd12);
      rob_if.commit_ready = 1'b0;

      // Two ports, two tags in one cycle.
      cdb_set(0, 4'd5, 32'hB5, 1'b0);
      cdb_set(1, 4'd6, 32'hB6, 1'b0);
      tick(); cdb_clear();
      cdb_set(0, 4'd4, 32'hC4, 1'b0);
      tick(); cdb_clear();
      rob_if.commit_ready = 1'b1;
      #1;
      chk("dual_c4_data", 64'(rob_if.commit_data), 64'hC4);
      tick();
      chk("dual_c5_valid", 64'(rob_if.commit_valid), 64'd1);
      chk("dual_c5_data", 64'(rob_if.commit_data), 64'hB5);
      tick();
      chk("dual_c6_valid", 64'(rob_if.commit_valid), 64'd1);
      chk("dual_c6_data", 64'(rob_if.commit_data), 64'hB6);
      tick();
      chk("c7_not_done", 64'(rob_if.commit_valid), 64'd0);
      // Same tag on both ports: port 0 wins.
      cdb_set(0, 4'd7, 32'hD0, 1'b0);
      cdb_set(1, 4'd7, 32'hD1, 1'b0);
      tick(); cdb_clear();
      chk("same_tag_valid", 64'(rob_if.commit_valid), 64'd1);
      chk("same_tag_data", 64'(rob_if.commit_data), 64'hD0);
      tick();
      rob_if.commit_ready = 1'b0;
      chk("mid_count", 64'(rob_if.count), 64'd8);

      // Refill across the 15->0 wrap.
      for (int i = 0; i < 8; i++) begin
         rob_if.dispatch_valid   = 1'b1;
         rob_if.dispatch_dst_reg = 5'(20 + i);
         #1;
         chk("wrap_tag", 64'(rob_if.dispatch_tag), 64'(i));
         tick();
      end
      rob_if.dispatch_valid = 1'b0;
      chk("wrap_full_count", 64'(rob_if.count), 64'd16);
      chk("wrap_full_ready", 64'(rob_if.dispatch_ready), 64'd0);
      cdb_set(0, 4'd8, 32'hE8, 1'b0);
      tick(); cdb_clear();
      // Full with commit and dispatch requested together.
      rob_if.commit_ready     = 1'b1;
      rob_if.dispatch_valid   = 1'b1;
      rob_if.dispatch_dst_reg = 5'd30;
      #1;
      chk("fullc_commit_valid", 64'(rob_if.commit_valid), 64'd1);
      chk("fullc_commit_tag", 64'(rob_if.commit_tag), 64'd8);
      chk("fullc_no_passthru", 64'(rob_if.dispatch_ready), 64'd0);
      tick();
      chk("fullc_ready_next", 64'(rob_if.dispatch_ready), 64'd1);
      chk("fullc_tag_old_head", 64'(rob_if.dispatch_tag), 64'd8);
      chk("fullc_count", 64'(rob_if.count), 64'd15);
      tick();
      rob_if.dispatch_valid = 1'b0;
      rob_if.commit_ready   = 1'b0;
      chk("fullc_refilled", 64'(rob_if.count), 64'd16);

      // Clear before the branch scenario.
      rst = 1'b1;
      #1;
      chk("rst2_count", 64'(rob_if.count), 64'd0);
      rst = 1'b0;
      tick();

      // Branch at tag 0 plus four ALU ops, then mispredict.
      rob_if.dispatch_valid   = 1'b1;
      rob_if.dispatch_type    = commit_branch;
      rob_if.dispatch_dst_reg = 5'd0;
      #1;
      chk("br_tag", 64'(rob_if.dispatch_tag), 64'd0);
      tick();
      rob_if.dispatch_type = commit_alu;
      for (int i = 0; i < 4; i++) begin
         rob_if.dispatch_dst_reg = 5'(10 + i);
         tick();
      end
      rob_if.dispatch_valid = 1'b0;
      cdb_set(0, 4'd2, 32'h22, 1'b0);
      tick(); cdb_clear();
      cdb_set(0, 4'd0, 32'hF0, 1'b1);
      tick(); cdb_clear();
      rob_if.commit_ready     = 1'b1;
      rob_if.dispatch_valid   = 1'b1;
      rob_if.dispatch_dst_reg = 5'd15;
      cdb_set(1, 4'd3, 32'h33, 1'b0);
      #1;
      chk("br_commit_valid", 64'(rob_if.commit_valid), 64'd1);
      chk("br_commit_type", 64'(rob_if.commit_type), 64'(commit_branch));
      chk("br_count", 64'(rob_if.count), 64'd5);
      chk("br_dispatch_blocked", 64'(rob_if.dispatch_ready), 64'd0);
      chk("br_flush_before", 64'(rob_if.flush), 64'd0);
      tick(); cdb_clear();
      rob_if.dispatch_valid = 1'b0;
      #1;
      chk("flush_pulse", 64'(rob_if.flush), 64'd1);
      chk("flush_count", 64'(rob_if.count), 64'd0);
      chk("flush_commit_valid", 64'(rob_if.commit_valid), 64'd0);
      chk("flush_ready", 64'(rob_if.dispatch_ready), 64'd1);
      tick();
      chk("flush_one_cycle", 64'(rob_if.flush), 64'd0);
      chk("flush_no_commit", 64'(rob_if.commit_valid), 64'd0);
      chk("flush_still_empty", 64'(rob_if.count), 64'd0);
      rob_if.dispatch_valid   = 1'b1;
      rob_if.dispatch_dst_reg = 5'd17;
      #1;
      chk("post_flush_tag", 64'(rob_if.dispatch_tag), 64'd1);
      tick();
      rob_if.dispatch_valid = 1'b0;
      chk("post_flush_count", 64'(rob_if.count), 64'd1);
      chk("post_flush_pending", 64'(rob_if.commit_valid), 64'd0);
      // Mispredict on a non-branch entry is ignored.
      cdb_set(0, 4'd1, 32'h77, 1'b1);
      tick(); cdb_clear();
      chk("alu_commit_valid", 64'(rob_if.commit_valid), 64'd1);
      chk("alu_commit_data", 64'(rob_if.commit_data), 64'h77);
      tick();
      chk("alu_no_flush", 64'(rob_if.flush), 64'd0);
      chk("alu_count", 64'(rob_if.count), 64'd0);
      rob_if.commit_ready = 1'b0;

      // Reset with 7 outstanding entries.
      rob_if.dispatch_valid = 1'b1;
      repeat (7) tick();
      rob_if.dispatch_valid = 1'b0;
      cdb_set(0, 4'd2, 32'h55, 1'b0);
      tick(); cdb_clear();
      chk("pre_rst_count", 64'(rob_if.count), 64'd7);
      chk("pre_rst_commit_valid", 64'(rob_if.commit_valid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_count", 64'(rob_if.count), 64'd0);
      chk("midrst_commit_valid", 64'(rob_if.commit_valid), 64'd0);
      chk("midrst_flush", 64'(rob_if.flush), 64'd0);
      chk("midrst_ready", 64'(rob_if.dispatch_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rob_if.dispatch_valid = 1'b1;
      #1;
      chk("postrst_ready", 64'(rob_if.dispatch_ready), 64'd1);
      chk("postrst_tag", 64'(rob_if.dispatch_tag), 64'd0);
      tick();
      rob_if.dispatch_valid = 1'b0;
      chk("postrst_count", 64'(rob_if.count), 64'd1);
      chk("postrst_flush", 64'(rob_if.flush), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
